// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-target block.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEV       = 3'd1,
    ACK_DEV   = 3'd2,
    SUB       = 3'd3,
    ACK_SUB   = 3'd4,
    DATA      = 3'd5,
    ACK_DATA  = 3'd6,
    NACK_WAIT = 3'd7
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h1A;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

  // Bus level the target presents on SDA for a given drive-enable.
  function automatic logic ack_bit(input logic drive);
    return drive ? ACK : NACK;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus consecutive-sample glitch filter with edge pulses.
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic RESET,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Accept a new level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= CW'(cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/i2c_slave_writer_rx.sv
// I2C write-only target: decodes dev-addr / sub-addr / data into register-write strobes.
module i2c_slave_writer_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEF,
  parameter int unsigned FILT_LEN = 3,
  parameter bit          AUTO_INC = 1'b1
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDATA,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       nack_evt
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .RESET(RESET), .din(I2C_SCLK),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .RESET(RESET), .din(I2C_SDATA),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       first_data, first_data_nxt;
  logic       nack_pend, nack_pend_nxt;
  logic       sda_oe, sda_oe_nxt;
  logic       busy_nxt, wr_valid_nxt, nack_evt_nxt;
  logic [7:0] wr_addr_nxt, wr_data_nxt;
  logic [7:0] rx_byte;
  logic       start_c, stop_c;

  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;
  assign rx_byte = {shreg[6:0], sda_lvl};

  // Open-drain: only ever pull SDA low, otherwise release.
  assign I2C_SDATA = (ack_bit(sda_oe) == ACK) ? 1'b0 : 1'bz;

  // State and datapath registers; reset releases SDA asynchronously.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      first_data <= 1'b0;
      nack_pend  <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_valid   <= 1'b0;
      nack_evt   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      first_data <= first_data_nxt;
      nack_pend  <= nack_pend_nxt;
      sda_oe     <= sda_oe_nxt;
      busy       <= busy_nxt;
      wr_valid   <= wr_valid_nxt;
      nack_evt   <= nack_evt_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
    end
  end

  // Next-state and output decode; START/STOP override bit processing.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    first_data_nxt = first_data;
    nack_pend_nxt  = nack_pend;
    sda_oe_nxt     = sda_oe;
    busy_nxt       = busy;
    wr_valid_nxt   = 1'b0;
    nack_evt_nxt   = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;

    if (stop_c) begin
      state_nxt     = IDLE;
      bit_cnt_nxt   = '0;
      nack_pend_nxt = 1'b0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
    end else if (start_c) begin
      state_nxt     = DEV;
      bit_cnt_nxt   = '0;
      nack_pend_nxt = 1'b0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b1;
    end else begin
      case (state)
        DEV, SUB, DATA: begin
          if (scl_rise) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = 3'(bit_cnt + 3'd1);
            if (bit_cnt == 3'd7) begin
              bit_cnt_nxt = '0;
              if (state == DEV) begin
                if (rx_byte[7:1] == DEV_ADDR && rx_byte[0] == 1'b0) begin
                  state_nxt = ACK_DEV;
                end else begin
                  state_nxt     = NACK_WAIT;
                  nack_pend_nxt = 1'b1;
                end
              end else if (state == SUB) begin
                wr_addr_nxt    = rx_byte;
                first_data_nxt = 1'b1;
                state_nxt      = ACK_SUB;
              end else if (first_data || AUTO_INC) begin
                if (!first_data) wr_addr_nxt = 8'(wr_addr + 8'd1);
                first_data_nxt = 1'b0;
                wr_data_nxt    = rx_byte;
                wr_valid_nxt   = 1'b1;
                state_nxt      = ACK_DATA;
              end else begin
                state_nxt     = NACK_WAIT;
                nack_pend_nxt = 1'b1;
              end
            end
          end
        end
        ACK_DEV, ACK_SUB, ACK_DATA: begin
          // First fall starts the ACK drive, the 9th fall ends it.
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = (state == ACK_DEV) ? SUB : DATA;
            end
          end
        end
        NACK_WAIT: begin
          if (scl_rise && nack_pend) begin
            nack_evt_nxt  = 1'b1;
            nack_pend_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_writer_rx.sv
// Directed bench: bit-banged I2C master driving the write target.
module tb_i2c_slave_writer_rx;

  localparam int Q = 25;  // clk cycles per quarter SCL period

  logic       clk;
  logic       RESET;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       nack_evt;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_nack = 0;
  logic [7:0] sa [0:31];
  logic [7:0] sd [0:31];

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_writer_rx dut (
    .clk(clk), .RESET(RESET), .I2C_SCLK(scl), .I2C_SDATA(sda),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .nack_evt(nack_evt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Record every strobe and NACK pulse cycle.
  always @(negedge clk) begin
    if (wr_valid) begin
      sa[n_strobe % 32] = wr_addr;
      sd[n_strobe % 32] = wr_data;
      n_strobe = n_strobe + 1;
    end
    if (nack_evt) n_nack = n_nack + 1;
  end

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b1; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b0; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; tick(Q);
    scl = 1'b1; tick(Q);
    tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  // Ninth clock with SDA released; returns the sampled bus level (0 = ACK).
  task automatic rd_ack(output logic a);
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    a = sda;      tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    rd_ack(a);
  endtask

  logic a0, a1, a2, a3;
  int   sb, nb;

  initial begin
    RESET = 1'b0; scl = 1'b1; m_low = 1'b0;
    tick(5);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_nack_evt", {31'd0, nack_evt}, 32'd0);
    check("rst_sda", {31'd0, sda}, 32'd1);
    RESET = 1'b1;
    tick(10);

    // 1: plain write 0x34 / 0x0E / 0x42
    sb = n_strobe; nb = n_nack;
    i2c_start();
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(8'h34, a0); send_byte(8'h0E, a1); send_byte(8'h42, a2);
    i2c_stop();
    check("t1_ack_dev", {31'd0, a0}, 32'd0);
    check("t1_ack_sub", {31'd0, a1}, 32'd0);
    check("t1_ack_data", {31'd0, a2}, 32'd0);
    check("t1_strobes", n_strobe - sb, 32'd1);
    check("t1_addr", {24'd0, sa[sb % 32]}, 32'h0E);
    check("t1_data", {24'd0, sd[sb % 32]}, 32'h42);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_nacks", n_nack - nb, 32'd0);
    check("t1_hold_addr", {24'd0, wr_addr}, 32'h0E);
    check("t1_hold_data", {24'd0, wr_data}, 32'h42);
    tick(Q);

    // 2: wrong device address
    sb = n_strobe; nb = n_nack;
    i2c_start();
    send_byte(8'h36, a0); send_byte(8'h0E, a1); send_byte(8'h42, a2);
    i2c_stop();
    check("t2_ack_dev", {31'd0, a0}, 32'd1);
    check("t2_ack_sub", {31'd0, a1}, 32'd1);
    check("t2_ack_data", {31'd0, a2}, 32'd1);
    check("t2_nacks", n_nack - nb, 32'd1);
    check("t2_strobes", n_strobe - sb, 32'd0);
    tick(Q);

    // 3: read request is refused
    sb = n_strobe; nb = n_nack;
    i2c_start();
    send_byte(8'h35, a0);
    i2c_stop();
    check("t3_ack_dev", {31'd0, a0}, 32'd1);
    check("t3_nacks", n_nack - nb, 32'd1);
    check("t3_strobes", n_strobe - sb, 32'd0);
    check("t3_busy_end", {31'd0, busy}, 32'd0);
    tick(Q);

    // 4: auto-increment wraps 0xFF -> 0x00
    sb = n_strobe; nb = n_nack;
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'hFF, a1); send_byte(8'h11, a2); send_byte(8'h22, a3);
    i2c_stop();
    check("t4_ack0", {31'd0, a0}, 32'd0);
    check("t4_ack1", {31'd0, a1}, 32'd0);
    check("t4_ack2", {31'd0, a2}, 32'd0);
    check("t4_ack3", {31'd0, a3}, 32'd0);
    check("t4_strobes", n_strobe - sb, 32'd2);
    check("t4_addr0", {24'd0, sa[sb % 32]}, 32'hFF);
    check("t4_data0", {24'd0, sd[sb % 32]}, 32'h11);
    check("t4_addr1", {24'd0, sa[(sb + 1) % 32]}, 32'h00);
    check("t4_data1", {24'd0, sd[(sb + 1) % 32]}, 32'h22);
    check("t4_nacks", n_nack - nb, 32'd0);
    tick(Q);

    // 5: STOP after a partial data byte, then a full write
    sb = n_strobe;
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h05, a1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    check("t5_partial_strobes", n_strobe - sb, 32'd0);
    check("t5_partial_busy", {31'd0, busy}, 32'd0);
    tick(Q);
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h06, a1); send_byte(8'h77, a2);
    i2c_stop();
    check("t5_strobes", n_strobe - sb, 32'd1);
    check("t5_addr", {24'd0, sa[sb % 32]}, 32'h06);
    check("t5_data", {24'd0, sd[sb % 32]}, 32'h77);
    tick(Q);

    // 6: reset while driving the sub-address ACK
    sb = n_strobe;
    i2c_start();
    send_byte(8'h34, a0);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h0E >> i));
    m_low = 1'b0;
    tick(Q);
    check("t6_ack_driven", {31'd0, sda}, 32'd0);
    RESET = 1'b0;
    #1;
    check("t6_rst_sda", {31'd0, sda}, 32'd1);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_valid", {31'd0, wr_valid}, 32'd0);
    tick(4);
    RESET = 1'b1;
    scl = 1'b1;
    tick(4 * Q);
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h10, a1); send_byte(8'h99, a2);
    i2c_stop();
    check("t6_ack_sub", {31'd0, a1}, 32'd0);
    check("t6_strobes", n_strobe - sb, 32'd1);
    check("t6_addr", {24'd0, sa[sb % 32]}, 32'h10);
    check("t6_data", {24'd0, sd[sb % 32]}, 32'h99);
    tick(Q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
